// File: rtl/sprite_pkg.sv
// Shared types for the sprite character blocks: facing codes, latched
// command encoding, controller states and the sprite ROM address width.
package sprite_pkg;

  typedef enum logic [1:0] {
    F_UP    = 2'b00,
    F_DOWN  = 2'b01,
    F_LEFT  = 2'b10,
    F_RIGHT = 2'b11
  } facing_e;

  typedef enum logic [2:0] {
    NO_ACTION = 3'd0,
    ATTACK    = 3'd1,
    UP        = 3'd2,
    DOWN      = 3'd3,
    LEFT      = 3'd4,
    RIGHT     = 3'd5
  } cmd_e;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LATCH = 3'd1,
    S_APPLY = 3'd2,
    S_DRAW  = 3'd3,
    S_FLUSH = 3'd4
  } state_e;

  // Sheet holds four facing rows of (walk frames + attack frame) sprites.
  function automatic int rom_aw(input int spr_w, input int spr_h, input int anim_frames);
    return $clog2(spr_w * spr_h * 4 * (anim_frames + 1));
  endfunction

endpackage

// File: rtl/sprite_char_ctrl_if.sv
// Bundle of frame-control, command, collision, sprite ROM and VGA signals
// seen by one sprite character. master = surrounding system, slave = sprite.
interface sprite_char_ctrl_if
  import sprite_pkg::*;
#(
  parameter int X_W    = 9,
  parameter int Y_W    = 8,
  parameter int COL_W  = 6,
  parameter int ROM_AW = rom_aw(16, 16, 2)
);
  logic              init;
  logic              frame_start;
  logic              c_attack;
  logic              c_up;
  logic              c_down;
  logic              c_left;
  logic              c_right;
  logic [3:0]        collision;
  logic [X_W-1:0]    x_pos;
  logic [Y_W-1:0]    y_pos;
  logic [1:0]        facing;
  logic              attacking;
  logic [ROM_AW-1:0] rom_addr;
  logic [COL_W-1:0]  rom_data;
  logic [X_W-1:0]    x_draw;
  logic [Y_W-1:0]    y_draw;
  logic [COL_W-1:0]  colour;
  logic              vga_write;
  logic              busy;
  logic              done;

  modport master (
    output init, frame_start, c_attack, c_up, c_down, c_left, c_right,
           collision, rom_data,
    input  x_pos, y_pos, facing, attacking, rom_addr, x_draw, y_draw,
           colour, vga_write, busy, done
  );

  modport slave (
    input  init, frame_start, c_attack, c_up, c_down, c_left, c_right,
           collision, rom_data,
    output x_pos, y_pos, facing, attacking, rom_addr, x_draw, y_draw,
           colour, vga_write, busy, done
  );
endinterface

// File: rtl/sprite_raster_gen.sv
// Walks one sprite tile in raster order, addresses the sprite ROM and
// emits ROM-aligned VGA pixel writes with the transparent colour gated off.
module sprite_raster_gen
  import sprite_pkg::*;
#(
  parameter int SPR_W = 16,
  parameter int SPR_H = 16,
  parameter int X_W   = 9,
  parameter int Y_W   = 8,
  parameter int COL_W = 6,
  parameter int BW    = 2,
  parameter logic [COL_W-1:0] TRANSPARENT = 6'h3F,
  localparam int PXW  = $clog2(SPR_W),
  localparam int PYW  = $clog2(SPR_H),
  localparam int CW   = PXW + PYW,
  localparam int AW   = 2 + BW + CW
)(
  input  logic             clock,
  input  logic             resetn,
  input  logic             clear,
  input  logic             start,
  input  logic [X_W-1:0]   base_x,
  input  logic [Y_W-1:0]   base_y,
  input  logic [1:0]       row,
  input  logic [BW-1:0]    block,
  output logic [AW-1:0]    rom_addr,
  input  logic [COL_W-1:0] rom_data,
  output logic [X_W-1:0]   x_draw,
  output logic [Y_W-1:0]   y_draw,
  output logic [COL_W-1:0] colour,
  output logic             vga_write,
  output logic             last,
  output logic             done
);
  logic [CW-1:0]  cnt;
  logic [PXW-1:0] px;
  logic [PYW-1:0] py;
  logic           active;
  logic           vld;
  logic           flush_q;

  assign px       = cnt[PXW-1:0];
  assign py       = cnt[CW-1:PXW];
  assign rom_addr = {row, block, py, px};
  // Tile size is a power of two, so the final pixel is the all-ones count.
  assign last     = active && (&cnt);

  // rom_data arrives one cycle after rom_addr; coordinates are delayed to match.
  assign colour    = vld ? rom_data : '0;
  assign vga_write = vld && (rom_data != TRANSPARENT);

  // Pixel counter, alignment pipe and end-of-pass pulse.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt     <= '0;
      active  <= 1'b0;
      vld     <= 1'b0;
      flush_q <= 1'b0;
      done    <= 1'b0;
      x_draw  <= '0;
      y_draw  <= '0;
    end else if (clear) begin
      cnt     <= '0;
      active  <= 1'b0;
      vld     <= 1'b0;
      flush_q <= 1'b0;
      done    <= 1'b0;
      x_draw  <= '0;
      y_draw  <= '0;
    end else begin
      vld     <= active;
      flush_q <= last;
      done    <= flush_q;
      if (active) begin
        x_draw <= base_x + X_W'(px);
        y_draw <= base_y + Y_W'(py);
      end
      if (start) begin
        active <= 1'b1;
        cnt    <= '0;
      end else if (active) begin
        cnt <= cnt + 1'b1;
        if (last) active <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/sprite_char_ctrl.sv
// One movable sprite character: per frame latches a command, applies
// movement/attack with collision and screen bounds, then draws the sprite.
//
//   state   | meaning
//   S_IDLE  | waiting for frame_start
//   S_LATCH | capture highest-priority command
//   S_APPLY | update position, facing, animation and attack timer
//   S_DRAW  | stream sprite pixels from ROM to VGA
//   S_FLUSH | last aligned pixel leaves; done follows
module sprite_char_ctrl
  import sprite_pkg::*;
#(
  parameter int SPR_W       = 16,
  parameter int SPR_H       = 16,
  parameter int X_W         = 9,
  parameter int Y_W         = 8,
  parameter int COL_W       = 6,
  parameter int STEP        = 1,
  parameter int ANIM_FRAMES = 2,
  parameter int ANIM_DIV    = 8,
  parameter int ATK_FRAMES  = 12,
  parameter int START_X     = 127,
  parameter int START_Y     = 88,
  parameter int X_MAX       = 303,
  parameter int Y_MAX       = 223,
  parameter logic [COL_W-1:0] TRANSPARENT = 6'h3F
)(
  input logic               clock,
  input logic               resetn,
  sprite_char_ctrl_if.slave bus
);
  localparam int BW  = $clog2(ANIM_FRAMES + 1);
  localparam int AFW = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1;
  localparam int MCW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam int ACW = (ATK_FRAMES > 1) ? $clog2(ATK_FRAMES) : 1;
  localparam int AW  = rom_aw(SPR_W, SPR_H, ANIM_FRAMES);

  localparam logic [X_W-1:0] X_START = X_W'(START_X);
  localparam logic [Y_W-1:0] Y_START = Y_W'(START_Y);
  localparam logic [X_W-1:0] X_STEP  = X_W'(STEP);
  localparam logic [Y_W-1:0] Y_STEP  = Y_W'(STEP);
  localparam logic [X_W:0]   X_STEP_E = (X_W+1)'(STEP);
  localparam logic [Y_W:0]   Y_STEP_E = (Y_W+1)'(STEP);
  localparam logic [X_W:0]   X_MAX_E = (X_W+1)'(X_MAX);
  localparam logic [Y_W:0]   Y_MAX_E = (Y_W+1)'(Y_MAX);
  localparam logic [X_W-1:0] X_MAX_T = X_W'(X_MAX);
  localparam logic [Y_W-1:0] Y_MAX_T = Y_W'(Y_MAX);

  state_e          state;
  cmd_e            cmd;
  cmd_e            cmd_sel;
  facing_e         facing_q;
  facing_e         dir;
  logic [X_W-1:0]  x_pos_q;
  logic [Y_W-1:0]  y_pos_q;
  logic            attacking_q;
  logic [ACW-1:0]  atk_cnt;
  logic [MCW-1:0]  move_cnt;
  logic [AFW-1:0]  anim_frame;
  logic            busy_q;
  logic [X_W-1:0]  x_next;
  logic [Y_W-1:0]  y_next;
  logic [X_W:0]    x_inc;
  logic [Y_W:0]    y_inc;
  logic            is_move;
  logic            blocked;
  logic            moved;
  logic [BW-1:0]   block;
  logic [AW-1:0]   rom_addr_w;
  logic            draw_last;

  assign x_inc = {1'b0, x_pos_q} + X_STEP_E;
  assign y_inc = {1'b0, y_pos_q} + Y_STEP_E;
  assign block = attacking_q ? BW'(ANIM_FRAMES) : BW'(anim_frame);

  // Command priority; a repeat attack falls through to the movement keys.
  always_comb begin
    cmd_sel = NO_ACTION;
    if (bus.c_attack && !attacking_q) cmd_sel = ATTACK;
    else if (bus.c_up)                cmd_sel = UP;
    else if (bus.c_down)              cmd_sel = DOWN;
    else if (bus.c_left)              cmd_sel = LEFT;
    else if (bus.c_right)             cmd_sel = RIGHT;
  end

  // Candidate position for the latched move, clamped to the screen.
  always_comb begin
    x_next  = x_pos_q;
    y_next  = y_pos_q;
    dir     = facing_q;
    is_move = 1'b0;
    blocked = 1'b1;
    case (cmd)
      UP: begin
        is_move = 1'b1;
        dir     = F_UP;
        blocked = bus.collision[0];
        y_next  = (y_pos_q >= Y_STEP) ? (y_pos_q - Y_STEP) : '0;
      end
      DOWN: begin
        is_move = 1'b1;
        dir     = F_DOWN;
        blocked = bus.collision[1];
        y_next  = (y_inc > Y_MAX_E) ? Y_MAX_T : y_inc[Y_W-1:0];
      end
      LEFT: begin
        is_move = 1'b1;
        dir     = F_LEFT;
        blocked = bus.collision[2];
        x_next  = (x_pos_q >= X_STEP) ? (x_pos_q - X_STEP) : '0;
      end
      RIGHT: begin
        is_move = 1'b1;
        dir     = F_RIGHT;
        blocked = bus.collision[3];
        x_next  = (x_inc > X_MAX_E) ? X_MAX_T : x_inc[X_W-1:0];
      end
      default: ;
    endcase
    moved = is_move && !blocked && ((x_next != x_pos_q) || (y_next != y_pos_q));
  end

  // Pass sequencing and character state update.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state       <= S_IDLE;
      cmd         <= NO_ACTION;
      x_pos_q     <= X_START;
      y_pos_q     <= Y_START;
      facing_q    <= F_DOWN;
      attacking_q <= 1'b0;
      atk_cnt     <= '0;
      move_cnt    <= '0;
      anim_frame  <= '0;
      busy_q      <= 1'b0;
    end else if (bus.init) begin
      state       <= S_IDLE;
      cmd         <= NO_ACTION;
      x_pos_q     <= X_START;
      y_pos_q     <= Y_START;
      facing_q    <= F_DOWN;
      attacking_q <= 1'b0;
      atk_cnt     <= '0;
      move_cnt    <= '0;
      anim_frame  <= '0;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.frame_start) begin
            state  <= S_LATCH;
            busy_q <= 1'b1;
          end
        end
        S_LATCH: begin
          cmd   <= cmd_sel;
          state <= S_APPLY;
        end
        S_APPLY: begin
          if (cmd == ATTACK) begin
            attacking_q <= 1'b1;
            atk_cnt     <= ACW'(ATK_FRAMES - 1);
          end else if (attacking_q) begin
            if (atk_cnt == '0) attacking_q <= 1'b0;
            else               atk_cnt     <= atk_cnt - 1'b1;
          end else if (is_move) begin
            facing_q <= dir;
            if (moved) begin
              x_pos_q <= x_next;
              y_pos_q <= y_next;
              if (move_cnt == MCW'(ANIM_DIV - 1)) begin
                move_cnt   <= '0;
                anim_frame <= (ANIM_FRAMES == 1) ? '0 : anim_frame + 1'b1;
              end else begin
                move_cnt <= move_cnt + 1'b1;
              end
            end
          end
          state <= S_DRAW;
        end
        S_DRAW: begin
          if (draw_last) state <= S_FLUSH;
        end
        S_FLUSH: begin
          state  <= S_IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          state  <= S_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  sprite_raster_gen #(
    .SPR_W       (SPR_W),
    .SPR_H       (SPR_H),
    .X_W         (X_W),
    .Y_W         (Y_W),
    .COL_W       (COL_W),
    .BW          (BW),
    .TRANSPARENT (TRANSPARENT)
  ) u_raster (
    .clock     (clock),
    .resetn    (resetn),
    .clear     (bus.init),
    .start     (state == S_APPLY),
    .base_x    (x_pos_q),
    .base_y    (y_pos_q),
    .row       (facing_q),
    .block     (block),
    .rom_addr  (rom_addr_w),
    .rom_data  (bus.rom_data),
    .x_draw    (bus.x_draw),
    .y_draw    (bus.y_draw),
    .colour    (bus.colour),
    .vga_write (bus.vga_write),
    .last      (draw_last),
    .done      (bus.done)
  );

  assign bus.rom_addr  = rom_addr_w;
  assign bus.x_pos     = x_pos_q;
  assign bus.y_pos     = y_pos_q;
  assign bus.facing    = facing_q;
  assign bus.attacking = attacking_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_sprite_char_ctrl.sv
// Scoreboard bench for sprite_char_ctrl: a pass-level model predicts the
// character state and every non-transparent pixel write of each pass.
module tb_sprite_char_ctrl;
  import sprite_pkg::*;

  localparam int SPR_W = 16, SPR_H = 16, NPIX = SPR_W * SPR_H;
  localparam int X_MAX = 303, Y_MAX = 223, STEP = 1;
  localparam int AF = 2, ANIM_DIV = 8, ATK = 12, SX = 127, SY = 88;
  localparam int BLK_STRIDE = 4;
  localparam int LAT = 3 + NPIX;

  logic clock = 1'b0;
  logic resetn = 1'b0;
  always #5 clock = ~clock;

  sprite_char_ctrl_if bus ();
  sprite_char_ctrl dut (.clock(clock), .resetn(resetn), .bus(bus));

  logic [5:0] rom_mem [0:4095];
  always @(posedge clock) bus.rom_data <= rom_mem[bus.rom_addr];

  typedef struct {int x; int y; int c;} pix_t;
  typedef struct {int x; int y; int f; int a;} st_t;
  pix_t pix_q[$];
  st_t  st_q[$];
  pix_t p;
  st_t  s;

  int n_cmp = 0, n_err = 0;
  int mx, my, mf, matk, mleft, mmv, manim, mblk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mx = SX; my = SY; mf = 1; matk = 0; mleft = 0; mmv = 0; manim = 0;
  endtask

  // One pass of the character rules, then the pixels it should write.
  task automatic model_pass(input bit a, u, d, l, r, input logic [3:0] col);
    int dir, nx, ny, addr;
    pix_t pp;
    st_t  ss;
    dir = -1;
    if (u) dir = 0; else if (d) dir = 1; else if (l) dir = 2; else if (r) dir = 3;
    if (a && matk == 0) begin
      matk = 1; mleft = ATK - 1;
    end else if (matk != 0) begin
      if (mleft == 0) matk = 0; else mleft--;
    end else if (dir >= 0) begin
      nx = mx; ny = my; mf = dir;
      case (dir)
        0: ny = (my - STEP < 0) ? 0 : my - STEP;
        1: ny = (my + STEP > Y_MAX) ? Y_MAX : my + STEP;
        2: nx = (mx - STEP < 0) ? 0 : mx - STEP;
        default: nx = (mx + STEP > X_MAX) ? X_MAX : mx + STEP;
      endcase
      if (!col[dir] && (nx != mx || ny != my)) begin
        mx = nx; my = ny; mmv++;
        if (mmv == ANIM_DIV) begin mmv = 0; manim = (manim + 1) % AF; end
      end
    end
    mblk = (matk != 0) ? AF : manim;
    for (int py = 0; py < SPR_H; py++)
      for (int px = 0; px < SPR_W; px++) begin
        addr = (mf * BLK_STRIDE + mblk) * NPIX + py * SPR_W + px;
        if (rom_mem[addr] != 6'h3F) begin
          pp.x = mx + px; pp.y = my + py; pp.c = int'(rom_mem[addr]);
          pix_q.push_back(pp);
        end
      end
    ss.x = mx; ss.y = my; ss.f = mf; ss.a = matk;
    st_q.push_back(ss);
  endtask

  task automatic set_cmd(input bit a, u, d, l, r, input logic [3:0] col);
    bus.c_attack = a; bus.c_up = u; bus.c_down = d;
    bus.c_left = l; bus.c_right = r; bus.collision = col;
  endtask

  task automatic do_pass(input bit a, u, d, l, r, input logic [3:0] col);
    int n, exp_addr;
    bit seen;
    @(negedge clock); #1;
    set_cmd(a, u, d, l, r, col);
    model_pass(a, u, d, l, r, col);
    exp_addr = (mf * BLK_STRIDE + mblk) * NPIX + 7;
    bus.frame_start = 1'b1;
    n = 0; seen = 0;
    while (!seen && n < 400) begin
      @(negedge clock);
      n++;
      if (bus.done) seen = 1;
      if (n == 10) begin
        chk("busy_in_pass", int'(bus.busy), 1);
        chk("rom_addr_pix7", int'(bus.rom_addr), exp_addr);
      end
      if (n == 1) begin #1; bus.frame_start = 1'b0; end
    end
    chk("latency", n - 1, LAT);
  endtask

  task automatic fill_rom_random();
    for (int a = 0; a < 4096; a++)
      rom_mem[a] = ($urandom_range(0, 7) == 0) ? 6'h3F : 6'($urandom_range(0, 63));
  endtask

  // Monitor: pops expectations whenever the DUT writes a pixel or ends a pass.
  always @(negedge clock) begin
    if (resetn) begin
      if (bus.vga_write) begin
        if (pix_q.size() == 0) chk("unexpected_write", 1, 0);
        else begin
          p = pix_q.pop_front();
          chk("x_draw", int'(bus.x_draw), p.x);
          chk("y_draw", int'(bus.y_draw), p.y);
          chk("colour", int'(bus.colour), p.c);
        end
      end
      if (bus.done) begin
        chk("writes_left_at_done", pix_q.size(), 0);
        pix_q.delete();
        if (st_q.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          s = st_q.pop_front();
          chk("x_pos", int'(bus.x_pos), s.x);
          chk("y_pos", int'(bus.y_pos), s.y);
          chk("facing", int'(bus.facing), s.f);
          chk("attacking", int'(bus.attacking), s.a);
        end
      end
    end
  end

  initial begin
    bit a, u, d, l, r;
    logic [3:0] col;
    bus.init = 1'b0; bus.frame_start = 1'b0;
    set_cmd(0, 0, 0, 0, 0, 4'b0);
    for (int i = 0; i < 4096; i++) rom_mem[i] = 6'h3F;
    model_reset();

    #22;
    chk("rst_x_pos", int'(bus.x_pos), SX);
    chk("rst_y_pos", int'(bus.y_pos), SY);
    chk("rst_facing", int'(bus.facing), 1);
    chk("rst_attacking", int'(bus.attacking), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_vga_write", int'(bus.vga_write), 0);
    chk("rst_x_draw", int'(bus.x_draw), 0);
    @(negedge clock); #1 resetn = 1'b1;

    @(negedge clock); #1 bus.init = 1'b1;
    @(negedge clock); #1 bus.init = 1'b0;
    do_pass(0, 0, 0, 0, 0, 4'b0);

    // init together with frame_start: no pass may start.
    @(negedge clock); #1 bus.init = 1'b1; bus.frame_start = 1'b1;
    @(negedge clock); #1 bus.init = 1'b0; bus.frame_start = 1'b0;
    model_reset();
    repeat (3) begin
      @(negedge clock);
      chk("init_blocks_start", int'(bus.busy), 0);
    end

    for (int i = 0; i < 4096; i++) rom_mem[i] = 6'(i % 64);
    do_pass(0, 0, 0, 0, 0, 4'b0);

    fill_rom_random();
    do_pass(1, 0, 0, 0, 0, 4'b0);
    repeat (12) do_pass(0, 1, 0, 0, 0, 4'b0);
    chk("y_after_attack", int'(bus.y_pos), SY);

    @(negedge clock); #1 bus.init = 1'b1;
    @(negedge clock); #1 bus.init = 1'b0;
    model_reset();
    repeat (8) do_pass(0, 0, 0, 0, 1, 4'b0);
    chk("x_after_right8", int'(bus.x_pos), 135);
    do_pass(0, 0, 0, 0, 1, 4'b1000);
    chk("x_collision_right", int'(bus.x_pos), 135);
    chk("facing_collision_right", int'(bus.facing), 3);

    while (mx < X_MAX) do_pass(0, 0, 0, 0, 1, 4'b0);
    do_pass(0, 0, 0, 0, 1, 4'b0);
    chk("x_at_xmax", int'(bus.x_pos), X_MAX);
    chk("facing_at_xmax", int'(bus.facing), 3);

    fill_rom_random();
    repeat (20) begin
      a = ($urandom_range(0, 3) == 0);
      u = 1'($urandom_range(0, 1)); d = 1'($urandom_range(0, 1));
      l = 1'($urandom_range(0, 1)); r = 1'($urandom_range(0, 1));
      col = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
      do_pass(a, u, d, l, r, col);
    end

    // Reset in the middle of DRAW.
    @(negedge clock); #1;
    set_cmd(0, 0, 0, 0, 0, 4'b0);
    model_pass(0, 0, 0, 0, 0, 4'b0);
    bus.frame_start = 1'b1;
    @(negedge clock); #1 bus.frame_start = 1'b0;
    repeat (99) @(negedge clock);
    #1 resetn = 1'b0;
    #1;
    chk("midrst_x_pos", int'(bus.x_pos), SX);
    chk("midrst_y_pos", int'(bus.y_pos), SY);
    chk("midrst_facing", int'(bus.facing), 1);
    chk("midrst_attacking", int'(bus.attacking), 0);
    chk("midrst_busy", int'(bus.busy), 0);
    chk("midrst_vga_write", int'(bus.vga_write), 0);
    chk("midrst_x_draw", int'(bus.x_draw), 0);
    pix_q.delete();
    st_q.delete();
    model_reset();
    @(negedge clock); #1 resetn = 1'b1;
    do_pass(0, 0, 0, 0, 0, 4'b0);

    repeat (3) @(negedge clock);
    chk("pix_queue_drained", pix_q.size(), 0);
    chk("state_queue_drained", st_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/sprite_char_ctrl.md
Name: sprite_char_ctrl

Overview:
- Parametrised successor of the single-character movement/draw block: one movable sprite character, whether the player or an enemy.
- Per frame it latches a user or AI command, applies movement subject to collision and screen bounds, and advances walk/attack animation. It then streams the sprite pixels to the VGA write port.
- Sits between the frame-level control FSM (start/done handshake), the collision detector, an external sprite ROM (1-cycle read latency) and the VGA pixel mux.

Parameters:
- SPR_W, 16, sprite width in pixels (power of 2)
- SPR_H, 16, sprite height in pixels (power of 2)
- X_W, 9, x position width
- Y_W, 8, y position width
- COL_W, 6, colour width
- STEP, 1, pixels moved per accepted move
- ANIM_FRAMES, 2, walk frames per direction (power of 2)
- ANIM_DIV, 8, moves per walk-frame advance
- ATK_FRAMES, 12, frames an attack lasts
- START_X, 127, position after init
- START_Y, 88, position after init
- X_MAX, 303, largest legal x_pos
- Y_MAX, 223, largest legal y_pos
- TRANSPARENT, 6'h3F, colour key that is never written

Ports:
- clock  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- init  in  1  load start position (sync, highest priority after reset)
- frame_start  in  1  one-cycle pulse: begin one update+draw pass
- c_attack/c_up/c_down/c_left/c_right  in  1 each  commands
- collision  in  4  blocked flags {right,left,down,up}, valid in APPLY
- x_pos  out  X_W  top-left x
- y_pos  out  Y_W  top-left y
- facing  out  2  00 up, 01 down, 10 left, 11 right
- attacking  out  1  attack in progress
- rom_addr  out  log2(SPR_W*SPR_H*4*(ANIM_FRAMES+1))  sprite ROM address
- rom_data  in  COL_W  ROM data, valid 1 cycle after rom_addr
- x_draw  out  X_W  pixel x
- y_draw  out  Y_W  pixel y
- colour  out  COL_W  pixel colour
- vga_write  out  1  pixel write enable
- busy  out  1  pass in progress
- done  out  1  one-cycle pulse at end of pass

Behaviour:
- Reset (async, resetn=0):
  - x_pos/y_pos=START, facing=01, attacking=0, state=IDLE.
  - All counters, draw outputs, vga_write, busy and done = 0.
- init: same values as reset, applied synchronously; it aborts any pass in progress.
- FSM IDLE→LATCH→APPLY→DRAW→FLUSH→IDLE.
  - frame_start is ignored unless the state is IDLE.
  - busy=1 in every state except IDLE.
- LATCH (1 cycle): command priority is attack>up>down>left>right>none.
  - An attack while attacking=1 is ignored; the next priority command is latched instead.
- APPLY (1 cycle):
  - Attack: attacking←1, atk_cnt←ATK_FRAMES-1, position and facing unchanged.
  - Move while attacking=0: facing←dir. Position changes by STEP unless the matching collision bit is set or the bound would be crossed.
  - Bounds: no move below 0 or above X_MAX/Y_MAX, and no wrap. Clamp to the bound when STEP overshoots it.
  - Each accepted move increments move_cnt. When move_cnt reaches ANIM_DIV-1 it clears and anim_frame increments mod ANIM_FRAMES.
  - While attacking: movement commands are ignored. atk_cnt decrements each pass; attacking←0 when it is 0.
- Sprite sheet layout: row block = facing; column block = anim_frame, or ANIM_FRAMES when attacking.
  - rom_addr = {facing, block, py, px}.
- DRAW: a pixel counter runs 0..SPR_W*SPR_H-1, raster order with px as LSBs, and issues one rom_addr per cycle.
  - x_draw/y_draw/vga_write are delayed 1 cycle so they align with rom_data.
  - colour = rom_data.
  - vga_write = 1 only for aligned pixels with rom_data != TRANSPARENT.
- FLUSH: 1 cycle for the last pixel, then done=1 for exactly one cycle and the FSM returns to IDLE.
- Latency: frame_start → done = 3 + SPR_W*SPR_H cycles (259 at defaults).
- Widths: x_draw = x_pos + px. Results are truncated to X_W/Y_W; the bounds guarantee no overflow.
- frame_start coincident with init: init wins and no pass starts.

Decomposition:
- Package sprite_pkg holds:
  - facing codes F_UP/F_DOWN/F_LEFT/F_RIGHT
  - command enum NO_ACTION/ATTACK/UP/DOWN/LEFT/RIGHT
  - FSM state encoding
- One sub-module, sprite_raster_gen: pixel counter, ROM address formation, 1-cycle alignment pipe, transparency gating and done. It can be reused by enemy blocks.

Test Plan:
- Reset, then init, then frame_start with no command → pos (127,88), facing 01, done after exactly 259 cycles, no vga_write when every ROM word is 6'h3F.
- c_right held for 8 passes, no collision → x_pos 135, facing 11, anim_frame advances once to 1.
- x_pos at X_MAX=303 with c_right, or collision[3]=1 with c_right → x_pos unchanged, facing 11.
- c_attack at (127,88) → attacking=1 for 12 passes; c_up during attack leaves y_pos at 88; rom_addr column block = ANIM_FRAMES.
- ROM pattern = pixel index mod 64 → x_draw/y_draw/colour aligned, pixel (px=15,py=0) drawn at (142,88); writes suppressed where the value is 63.
- resetn asserted mid-DRAW → all outputs at reset values immediately; a new frame_start completes normally.
